alu_result_ctrl: RTL

Controller for the ALU's execution units (arithmetic, logic, comparator, shift). It accepts a function code from the system controller and drives ALU_FUN plus the matching unit enable. It then waits for the unit's registered result and valid flag, captures the result, and streams it byte-wise (LSB first) to the UART TX path over a valid/ready handshake. It is the initiator and consumer for the enable/flag/result protocol that every ALU sub-unit responds to.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_byte_serializer.sv | 51 +++++
 rtl/alu_result_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared FSM encoding and ALU unit-group / function-code constants used by the
// result controller and the execution units it drives.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_SEND = 2'b10
    } ctrl_state_t;

    // Unit group selected by CMD_FUN[3:2]
    localparam logic [1:0] GRP_ARITH = 2'b00;
    localparam logic [1:0] GRP_LOGIC = 2'b01;
    localparam logic [1:0] GRP_CMP   = 2'b10;
    localparam logic [1:0] GRP_SHIFT = 2'b11;

    localparam logic [3:0] CMP_NOP = 4'b1000;
    localparam logic [3:0] CMP_EQ  = 4'b1001;
    localparam logic [3:0] CMP_GT  = 4'b1010;
    localparam logic [3:0] CMP_LT  = 4'b1011;

endpackage

// File: rtl/alu_byte_serializer.sv
// Holds a captured ALU result and streams it LSB byte first over a
// valid/ready handshake; signals completion as the last byte is accepted.
module alu_byte_serializer
    import alu_pkg::*;
#(
    parameter int ALU_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [ALU_W-1:0] load_data,
    output logic [7:0]       TX_DATA,
    output logic             TX_VALID,
    input  logic             TX_READY,
    output logic             done
);

    localparam int NBYTES = ALU_W / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [ALU_W-1:0] result_p0;
    logic [IDX_W-1:0] byte_idx;
    logic             vld_p0;
    logic             last_byte;

    assign last_byte = (byte_idx == IDX_W'(NBYTES - 1));

    // Capture stage: a pending result is never overwritten while streaming
    always_ff @(posedge CLK) begin
        if (!RST) begin
            result_p0 <= '0;
            byte_idx  <= '0;
            vld_p0    <= 1'b0;
        end else if (load && !vld_p0) begin
            result_p0 <= load_data;
            byte_idx  <= '0;
            vld_p0    <= 1'b1;
        end else if (vld_p0 && TX_READY) begin
            if (last_byte) begin
                vld_p0 <= 1'b0;
            end else begin
                byte_idx <= byte_idx + IDX_W'(1);
            end
        end
    end

    assign TX_VALID = vld_p0;
    assign TX_DATA  = vld_p0 ? 8'(result_p0 >> {byte_idx, 3'b000}) : 8'h00;
    assign done     = vld_p0 && TX_READY && last_byte;

endmodule

// File: rtl/alu_result_ctrl.sv
// Issues a function code to the ALU execution units, waits (bounded) for the
// selected unit's result, then hands it to the byte serializer for UART TX.
module alu_result_ctrl
    import alu_pkg::*;
#(
    parameter int ALU_W   = 16,
    parameter int TIMEOUT = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [3:0]       CMD_FUN,
    output logic [3:0]       ALU_FUN,
    output logic             ARITH_EN,
    output logic             LOGIC_EN,
    output logic             CMP_EN,
    output logic             SHIFT_EN,
    input  logic [ALU_W-1:0] ALU_OUT,
    input  logic             ALU_VALID,
    output logic [7:0]       TX_DATA,
    output logic             TX_VALID,
    input  logic             TX_READY,
    output logic             BUSY,
    output logic             TIMEOUT_ERR
);

    localparam int CNT_W = $clog2(TIMEOUT);

    ctrl_state_t      state, state_nxt;
    logic [3:0]       fun_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             tmo_err_q;
    logic             ready_q;
    logic             accept;
    logic             capture;
    logic             tmo_hit;
    logic             ser_done;
    logic [3:0]       unit_en;

    // ready_q keeps CMD_READY low on the first cycle out of reset
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= ST_IDLE;
            fun_q     <= 4'h0;
            wait_cnt  <= '0;
            tmo_err_q <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            tmo_err_q <= tmo_hit;
            ready_q   <= 1'b1;
            if (accept) begin
                fun_q    <= CMD_FUN;
                wait_cnt <= '0;
            end else if (state == ST_EXEC) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (CMD_VALID && ready_q) begin
                    accept    = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // A result arriving on the limit cycle still wins over the timeout
                if (ALU_VALID) begin
                    capture   = 1'b1;
                    state_nxt = ST_SEND;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    tmo_hit   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (ser_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        unit_en = 4'b0000;
        if (state == ST_EXEC) begin
            case (fun_q[3:2])
                GRP_ARITH: unit_en[0] = 1'b1;
                GRP_LOGIC: unit_en[1] = 1'b1;
                GRP_CMP:   unit_en[2] = 1'b1;
                GRP_SHIFT: unit_en[3] = 1'b1;
                default:   unit_en    = 4'b0000;
            endcase
        end
    end

    assign ARITH_EN    = unit_en[0];
    assign LOGIC_EN    = unit_en[1];
    assign CMP_EN      = unit_en[2];
    assign SHIFT_EN    = unit_en[3];
    assign ALU_FUN     = fun_q;
    assign CMD_READY   = (state == ST_IDLE) && ready_q;
    assign BUSY        = (state != ST_IDLE);
    assign TIMEOUT_ERR = tmo_err_q;

    alu_byte_serializer #(
        .ALU_W (ALU_W)
    ) u_ser (
        .CLK       (CLK),
        .RST       (RST),
        .load      (capture),
        .load_data (ALU_OUT),
        .TX_DATA   (TX_DATA),
        .TX_VALID  (TX_VALID),
        .TX_READY  (TX_READY),
        .done      (ser_done)
    );

endmodule
